// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller with a three-state divider handshake FSM.
// Priority, highest first: memory wait, exception flush (live or pending),
// divider busy, load-use stall, branch flush.
// Optional stall-cycle counter is built only when PIPE_STALL_CNT_EN is defined;
// otherwise stall_cycles is tied to zero.
module pipe_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_stall,
  input  logic        d_stall,
  input  logic        lwstallD,
  input  logic        branchflushD,
  input  logic        div_startE,
  input  logic        div_ready,
  input  logic        excflush,
  output logic        enF,
  output logic        enD,
  output logic        enE,
  output logic        enM,
  output logic        enW,
  output logic        clrD,
  output logic        clrE,
  output logic        clrM,
  output logic        clrW,
  output logic        div_go,
  output logic        div_cancel,
  output logic [31:0] stall_cycles
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} div_st_e;

  div_st_e state_q, state_d;
  logic    flush_pend_q, flush_pend_d;
  logic    rdy_pend_q, rdy_pend_d;
  logic    mem_wait;

  assign mem_wait = i_stall | d_stall;

  // Stage control and next-state decode, in priority order.
  always_comb begin
    enF = 1'b1; enD = 1'b1; enE = 1'b1; enM = 1'b1; enW = 1'b1;
    clrD = 1'b0; clrE = 1'b0; clrM = 1'b0; clrW = 1'b0;
    div_go = 1'b0;
    div_cancel = 1'b0;
    state_d = state_q;
    flush_pend_d = flush_pend_q;
    rdy_pend_d = rdy_pend_q;
    if (rst) begin
      // Clear every stage and tell the divider to drop any operation.
      {clrD, clrE, clrM, clrW} = 4'hF;
      div_cancel = 1'b1;
      state_d = IDLE;
      flush_pend_d = 1'b0;
      rdy_pend_d = 1'b0;
    end else if (mem_wait) begin
      // Freeze everything; remember flush/ready events for when the wait ends.
      {enF, enD, enE, enM, enW} = 5'h0;
      flush_pend_d = flush_pend_q | excflush;
      if (state_q == BUSY && div_ready) rdy_pend_d = 1'b1;
    end else if (excflush || flush_pend_q) begin
      {clrD, clrE, clrM, clrW} = 4'hF;
      flush_pend_d = 1'b0;
      rdy_pend_d = 1'b0;
      if (state_q != IDLE) begin
        div_cancel = 1'b1;
        state_d = IDLE;
      end
    end else if (state_q == BUSY) begin
      // Hold F/D/E on the divide, drain M/W with a bubble.
      {enF, enD, enE} = 3'b000;
      clrM = 1'b1;
      if (div_ready || rdy_pend_q) begin
        state_d = DONE;
        rdy_pend_d = 1'b0;
      end
    end else begin
      if (state_q == DONE) state_d = IDLE;
      if (state_q == IDLE && div_startE) begin
        div_go = 1'b1;
        state_d = BUSY;
      end
      if (lwstallD) begin
        enF = 1'b0;
        enD = 1'b0;
        clrE = 1'b1;
      end else if (branchflushD) begin
        clrD = 1'b1;
      end
    end
  end

  // FSM and pending-event registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      flush_pend_q <= 1'b0;
      rdy_pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      flush_pend_q <= flush_pend_d;
      rdy_pend_q <= rdy_pend_d;
    end
  end

`ifdef PIPE_STALL_CNT_EN
  logic [31:0] cnt_q;

  // Count cycles in which decode is held; wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= 32'd0;
    else if (!enD) cnt_q <= cnt_q + 32'd1;
  end

  assign stall_cycles = cnt_q;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: inputs change 1ns after posedge, outputs are
// sampled on the following negedge.
module tb_pipe_ctrl;
  logic clk = 1'b0;
  logic rst, i_stall, d_stall, lwstallD, branchflushD, div_startE, div_ready, excflush;
  logic enF, enD, enE, enM, enW, clrD, clrE, clrM, clrW, div_go, div_cancel;
  logic [31:0] stall_cycles;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk(clk), .rst(rst), .i_stall(i_stall), .d_stall(d_stall),
    .lwstallD(lwstallD), .branchflushD(branchflushD), .div_startE(div_startE),
    .div_ready(div_ready), .excflush(excflush),
    .enF(enF), .enD(enD), .enE(enE), .enM(enM), .enW(enW),
    .clrD(clrD), .clrE(clrE), .clrM(clrM), .clrW(clrW),
    .div_go(div_go), .div_cancel(div_cancel), .stall_cycles(stall_cycles)
  );

  // {enF,enD,enE,enM,enW, clrD,clrE,clrM,clrW, div_go,div_cancel}
  logic [10:0] ov;
  assign ov = {enF, enD, enE, enM, enW, clrD, clrE, clrM, clrW, div_go, div_cancel};

  localparam logic [10:0] IDL  = 11'b11111_0000_00;
  localparam logic [10:0] RSTV = 11'b11111_1111_01;
  localparam logic [10:0] WAIT = 11'b00000_0000_00;
  localparam logic [10:0] BSY  = 11'b00011_0010_00;
  localparam logic [10:0] GO   = 11'b11111_0000_10;
  localparam logic [10:0] FLS  = 11'b11111_1111_00;
  localparam logic [10:0] FLC  = 11'b11111_1111_01;
  localparam logic [10:0] LW   = 11'b00111_0100_00;
  localparam logic [10:0] BR   = 11'b11111_1000_00;

  localparam int S_IDLE = 0;
  localparam int S_BUSY = 1;
  localparam int S_DONE = 2;

  // Input bundle: {rst,i_stall,d_stall,lwstallD,branchflushD,div_startE,div_ready,excflush}
  localparam logic [7:0] N   = 8'b0000_0000;
  localparam logic [7:0] RST = 8'b1000_0000;
  localparam logic [7:0] IST = 8'b0100_0000;
  localparam logic [7:0] DST = 8'b0010_0000;
  localparam logic [7:0] LWS = 8'b0001_0000;
  localparam logic [7:0] BRF = 8'b0000_1000;
  localparam logic [7:0] STA = 8'b0000_0100;
  localparam logic [7:0] RDY = 8'b0000_0010;
  localparam logic [7:0] EXC = 8'b0000_0001;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs and stop at the sampling point of that cycle.
  task automatic cyc(input logic [7:0] v);
    @(posedge clk);
    #1;
    {rst, i_stall, d_stall, lwstallD, branchflushD, div_startE, div_ready, excflush} = v;
    @(negedge clk);
  endtask

  initial begin
    {rst, i_stall, d_stall, lwstallD, branchflushD, div_startE, div_ready, excflush} = RST;

    // Reset behaviour
    cyc(RST);  chk("rst_out", 32'(ov), 32'(RSTV));
    cyc(N);    chk("rst_state", int'(dut.state_q), S_IDLE);
               chk("idle_out", 32'(ov), 32'(IDL));
               chk("rst_cnt", stall_cycles, 32'd0);

    // Divide: start at 0, ready at 5, DONE at 6, IDLE at 7
    cyc(STA);  chk("div_go", 32'(ov), 32'(GO));
    for (int i = 1; i <= 4; i++) begin
      cyc(N);  chk($sformatf("div_busy%0d", i), 32'(ov), 32'(BSY));
    end
    cyc(RDY);  chk("div_busy5", 32'(ov), 32'(BSY));
    cyc(N);    chk("div_done_st", int'(dut.state_q), S_DONE);
               chk("div_done_out", 32'(ov), 32'(IDL));
    cyc(STA);  chk("div_idle_st", int'(dut.state_q), S_IDLE);
               chk("div_restart", 32'(ov), 32'(GO));
    cyc(EXC);  chk("cancel_busy", 32'(ov), 32'(FLC));
    cyc(N);    chk("cancel_idle", int'(dut.state_q), S_IDLE);

    // d_stall 3..6 with excflush at 4 -> flush at 7
    for (int c = 0; c < 3; c++) cyc(N);
    cyc(DST);       chk("wait3", 32'(ov), 32'(WAIT));
    cyc(DST | EXC); chk("wait4", 32'(ov), 32'(WAIT));
    cyc(DST);       chk("wait5", 32'(ov), 32'(WAIT));
    cyc(DST);       chk("wait6", 32'(ov), 32'(WAIT));
    cyc(N);         chk("flush7", 32'(ov), 32'(FLS));
    cyc(N);         chk("flush8_gone", 32'(ov), 32'(IDL));

    // Repeated flush requests during wait collapse to one
    cyc(IST | EXC); cyc(IST | EXC);
    cyc(N);    chk("flush_once", 32'(ov), 32'(FLS));
    cyc(N);    chk("flush_once_after", 32'(ov), 32'(IDL));

    // excflush at cycle 3 of BUSY
    cyc(STA);  chk("c_go", 32'(ov), 32'(GO));
    cyc(N); cyc(N);
    cyc(EXC);  chk("c_cancel3", 32'(ov), 32'(FLC));
    cyc(RDY);  chk("c_idle4", int'(dut.state_q), S_IDLE);
               chk("c_idle4_out", 32'(ov), 32'(IDL));
    cyc(N);    chk("c_nodone", int'(dut.state_q), S_IDLE);

    // Load-use vs branch
    cyc(LWS | BRF); chk("lw_over_br", 32'(ov), 32'(LW));
    cyc(LWS);       chk("lw_only", 32'(ov), 32'(LW));
    cyc(BRF);       chk("br_only", 32'(ov), 32'(BR));
    cyc(EXC | LWS | BRF); chk("exc_over_lw", 32'(ov), 32'(FLS));

    // div_ready during i_stall -> DONE after stall drops
    cyc(STA);       chk("p_go", 32'(ov), 32'(GO));
    cyc(N);         chk("p_busy", 32'(ov), 32'(BSY));
    cyc(IST | RDY); chk("p_wait_a", 32'(ov), 32'(WAIT));
    cyc(IST);       chk("p_wait_b", int'(dut.state_q), S_BUSY);
    cyc(N);         chk("p_busy_out", 32'(ov), 32'(BSY));
    cyc(N);         chk("p_done", int'(dut.state_q), S_DONE);
    cyc(N);         chk("p_idle", int'(dut.state_q), S_IDLE);

    // Reset mid-divide abandons it
    cyc(STA); cyc(N);
    cyc(RST);  chk("mid_rst_out", 32'(ov), 32'(RSTV));
    cyc(N);    chk("mid_rst_st", int'(dut.state_q), S_IDLE);
               chk("mid_rst_nogo", 32'(ov), 32'(IDL));

    // Stall counter
`ifdef PIPE_STALL_CNT_EN
    dut.cnt_q = 32'hFFFF_FFFE;
    cyc(LWS);
    cyc(LWS);  chk("cnt_max", stall_cycles, 32'hFFFF_FFFF);
    cyc(N);    chk("cnt_wrap", stall_cycles, 32'h0000_0000);
`else
    cyc(LWS);
    cyc(DST);
    cyc(N);    chk("cnt_off_a", stall_cycles, 32'd0);
    cyc(N);    chk("cnt_off_b", stall_cycles, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
